// File: rtl/zigzag_runlevel_4x4.sv
// rtl/zigzag_runlevel_4x4.sv - zigzag reorder of a quantised 4x4 block into (level, run) pairs
// Optional macro FIELD_SCAN_EN adds field_mode input selecting the field scan order.
module zigzag_runlevel_4x4 #(
    parameter int BIT_LENGTH = 15,
    parameter int RUN_W      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          ac_only,
`ifdef FIELD_SCAN_EN
    input  logic                          field_mode,
`endif
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [16*(BIT_LENGTH+1)-1:0]  quantized,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BIT_LENGTH:0]           out_level,
    output logic [RUN_W-1:0]              out_run,
    output logic                          out_last,
    output logic                          block_done,
    output logic [4:0]                    total_coeff,
    output logic [1:0]                    trailing_ones
);

    localparam int W = BIT_LENGTH + 1;

    // Raster source index for each scan position, position p at bits [4p+3:4p].
    localparam logic [63:0] FRAME_ZZ = {4'd15, 4'd14, 4'd11, 4'd7, 4'd10, 4'd13, 4'd12, 4'd9,
                                        4'd6,  4'd3,  4'd2,  4'd5, 4'd8,  4'd4,  4'd1,  4'd0};
`ifdef FIELD_SCAN_EN
    localparam logic [63:0] FIELD_ZZ = {4'd15, 4'd11, 4'd7, 4'd3, 4'd14, 4'd10, 4'd6, 4'd2,
                                        4'd13, 4'd9,  4'd5, 4'd12, 4'd8, 4'd1,  4'd4, 4'd0};
`endif

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    state_t           state;
    logic [W-1:0]     coef_buf [16];
    logic [15:0]      mask;
    logic [3:0]       k;
    logic [RUN_W-1:0] run;
    logic [4:0]       count;
    logic [1:0]       ones;

    logic [W-1:0]     scan_coef [16];
    logic [15:0]      scan_mask;
    logic [15:0]      above;
    logic             is_last;
    logic             level_is_one;

    // Reorder the incoming raster block into scan order so SCAN just walks k.
    always_comb begin
        for (int p = 0; p < 16; p++) begin
`ifdef FIELD_SCAN_EN
            if (field_mode)
                scan_coef[p] = quantized[int'(FIELD_ZZ[p*4 +: 4])*W +: W];
            else
                scan_coef[p] = quantized[int'(FRAME_ZZ[p*4 +: 4])*W +: W];
`else
            scan_coef[p] = quantized[int'(FRAME_ZZ[p*4 +: 4])*W +: W];
`endif
            scan_mask[p] = |scan_coef[p];
        end
    end

    assign above        = mask >> k;
    assign is_last      = (above[15:1] == 15'd0);
    assign level_is_one = (out_level == W'(1)) || (out_level == {W{1'b1}});
    assign in_ready     = reset && enable && (state == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            for (int i = 0; i < 16; i++) coef_buf[i] <= '0;
            mask          <= '0;
            k             <= '0;
            run           <= '0;
            count         <= '0;
            ones          <= '0;
            out_valid     <= 1'b0;
            out_level     <= '0;
            out_run       <= '0;
            out_last      <= 1'b0;
            block_done    <= 1'b0;
            total_coeff   <= '0;
            trailing_ones <= '0;
        end else begin
            // block_done is a strict one-cycle pulse even when enable later drops.
            block_done <= 1'b0;
            if (enable) begin
                case (state)
                    IDLE: begin
                        if (in_valid) begin
                            for (int i = 0; i < 16; i++) coef_buf[i] <= scan_coef[i];
                            mask  <= scan_mask;
                            run   <= '0;
                            count <= '0;
                            ones  <= '0;
                            k     <= ac_only ? 4'd1 : 4'd0;
                            state <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (mask[k]) begin
                            out_valid <= 1'b1;
                            out_level <= coef_buf[k];
                            out_run   <= run;
                            out_last  <= is_last;
                            state     <= EMIT;
                        end else begin
                            run <= run + RUN_W'(1);
                            if (k == 4'd15)
                                state <= DONE;
                            else
                                k <= k + 4'd1;
                        end
                    end
                    EMIT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            run       <= '0;
                            count     <= count + 5'd1;
                            if (level_is_one)
                                ones <= (ones == 2'd3) ? 2'd3 : ones + 2'd1;
                            else
                                ones <= 2'd0;
                            if (out_last) begin
                                state <= DONE;
                            end else begin
                                k     <= k + 4'd1;
                                state <= SCAN;
                            end
                        end
                    end
                    DONE: begin
                        block_done    <= 1'b1;
                        total_coeff   <= count;
                        trailing_ones <= ones;
                        state         <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_zigzag_runlevel_4x4.sv
// tb/tb_zigzag_runlevel_4x4.sv - scoreboard bench for zigzag_runlevel_4x4
module tb_zigzag_runlevel_4x4;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         ac_only;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] quantized;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [15:0]  out_level;
    logic [3:0]   out_run;
    logic         out_last;
    logic         block_done;
    logic [4:0]   total_coeff;
    logic [1:0]   trailing_ones;

    zigzag_runlevel_4x4 dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .ac_only(ac_only),
`ifdef FIELD_SCAN_EN
        .field_mode(1'b0),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .quantized(quantized),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_level(out_level),
        .out_run(out_run),
        .out_last(out_last),
        .block_done(block_done),
        .total_coeff(total_coeff),
        .trailing_ones(trailing_ones)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] level;
        logic [3:0]  run;
        logic        last;
    } pair_t;

    typedef struct {
        int tc;
        int t1;
    } done_t;

    pair_t pair_q[$];
    done_t done_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int load_cyc = 0;
    int done_cyc = 0;
    int first_valid_cyc = 0;
    int ready_mode = 0;
    bit prev_valid = 0;

    logic signed [15:0] blk [16];
    int zz [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom % 2);
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: walk the scan order, emit a pair per nonzero, then count trailing +-1 from the end.
    task automatic model_push(input bit ac);
        pair_t pl[$];
        pair_t e;
        done_t d;
        int run = 0;
        int t1 = 0;
        for (int p = (ac ? 1 : 0); p < 16; p++) begin
            if (blk[zz[p]] == 0) begin
                run++;
            end else begin
                e.level = blk[zz[p]];
                e.run   = 4'(run);
                e.last  = 1'b0;
                pl.push_back(e);
                run = 0;
            end
        end
        if (pl.size() > 0) pl[pl.size()-1].last = 1'b1;
        for (int i = pl.size() - 1; i >= 0; i--) begin
            if (pl[i].level == 16'h0001 || pl[i].level == 16'hFFFF) t1++;
            else break;
        end
        foreach (pl[i]) pair_q.push_back(pl[i]);
        d.tc = pl.size();
        d.t1 = (t1 > 3) ? 3 : t1;
        done_q.push_back(d);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (out_valid) begin
                if (pair_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pair actual_level=%0d expected=none", $signed(out_level));
                end else begin
                    chk("pair_level", longint'($signed(out_level)), longint'($signed(pair_q[0].level)));
                    chk("pair_run", out_run, pair_q[0].run);
                    chk("pair_last", out_last, pair_q[0].last);
                    if (out_ready && enable) void'(pair_q.pop_front());
                end
                if (!prev_valid) first_valid_cyc = cyc;
            end
            if (block_done) begin
                done_cyc = cyc;
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_block_done actual=1 expected=0");
                end else begin
                    chk("total_coeff", total_coeff, done_q[0].tc);
                    chk("trailing_ones", trailing_ones, done_q[0].t1);
                    void'(done_q.pop_front());
                end
            end
            prev_valid = out_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic clear_blk();
        for (int i = 0; i < 16; i++) blk[i] = 16'sd0;
    endtask

    task automatic send_block(input bit ac);
        int n = 0;
        @(posedge clk);
        #1;
        while (!in_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout actual=0 expected=1");
            return;
        end
        model_push(ac);
        for (int i = 0; i < 16; i++) quantized[i*16 +: 16] = blk[i];
        ac_only  = ac;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        load_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((pair_q.size() != 0 || done_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL wait_idle_timeout pairs_left=%0d dones_left=%0d expected=0", pair_q.size(), done_q.size());
            pair_q.delete();
            done_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic random_block(input int density);
        int r;
        clear_blk();
        for (int i = 0; i < 16; i++) begin
            if (int'($urandom % 100) < density) begin
                r = int'($urandom % 5);
                case (r)
                    0: blk[i] = 16'sd1;
                    1: blk[i] = -16'sd1;
                    2: blk[i] = 16'($urandom_range(2, 40));
                    3: blk[i] = -16'($urandom_range(2, 40));
                    default: blk[i] = 16'($urandom);
                endcase
                if (blk[i] == 0) blk[i] = 16'sh8000;
            end
        end
    endtask

    initial begin
        int n;
        reset     = 1'b0;
        enable    = 1'b1;
        ac_only   = 1'b0;
        in_valid  = 1'b0;
        quantized = '0;
        clear_blk();

        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_block_done", block_done, 0);
        chk("rst_total_coeff", total_coeff, 0);
        chk("rst_trailing_ones", trailing_ones, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("in_ready_after_release", in_ready, 1);

        clear_blk();
        blk[0] = 16'sd5; blk[1] = -16'sd1; blk[5] = 16'sd1;
        send_block(1'b0);
        wait_idle();

        clear_blk();
        send_block(1'b0);
        wait_idle();
        chk("allzero_done_latency", done_cyc - load_cyc, 17);

        send_block(1'b1);
        wait_idle();
        chk("allzero_ac_done_latency", done_cyc - load_cyc, 16);

        clear_blk();
        blk[0] = 16'sd9; blk[15] = -16'sd1;
        send_block(1'b1);
        wait_idle();

        ready_mode = 1;
        for (int i = 0; i < 16; i++) blk[i] = 16'sd1;
        send_block(1'b0);
        wait_idle();
        ready_mode = 0;

        clear_blk();
        blk[8] = -16'sd300;
        send_block(1'b0);
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready", in_ready, 0);
        end
        enable = 1'b1;
        wait_idle();
        chk("stall_first_pair_latency", first_valid_cyc - load_cyc, 9);

        ready_mode = 1;
        for (int b = 0; b < 40; b++) begin
            random_block((b % 3 == 0) ? 15 : ((b % 3 == 1) ? 50 : 90));
            send_block(1'($urandom % 2));
        end
        wait_idle();

        ready_mode = 2;
        for (int i = 0; i < 16; i++) blk[i] = 16'sd1;
        send_block(1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_out_valid", out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out_level", out_level, 0);
        chk("async_rst_out_run", out_run, 0);
        chk("async_rst_out_last", out_last, 0);
        chk("async_rst_total_coeff", total_coeff, 0);
        chk("async_rst_trailing_ones", trailing_ones, 0);
        chk("async_rst_in_ready", in_ready, 0);
        pair_q.delete();
        done_q.delete();
        ready_mode = 0;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        random_block(50);
        send_block(1'b0);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/zigzag_runlevel_4x4.md
Name: zigzag_runlevel_4x4

Overview:
Downstream stage of the 4x4 quantiser in the transform-coding path. It accepts one quantised 4x4 coefficient block and reorders it in zigzag scan order. It emits one (level, run) pair per nonzero coefficient through a valid/ready handshake, then reports TotalCoeff and TrailingOnes for the entropy coder.

Parameters:
BIT_LENGTH, 15, MSB index of each signed coefficient (coefficient width BIT_LENGTH+1)
RUN_W, 4, width of the run field (max run 15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  stage enable; low freezes all state and forces in_ready low
ac_only  input  1  sampled at load; 1 = skip scan position 0 (Intra16x16 AC / chroma AC block)
in_valid  input  1  quantised block present
in_ready  output  1  stage can accept a block
quantized  input  BIT_LENGTH+1 x16  signed coefficients, raster order (index = row*4+col)
out_valid  output  1  level/run pair valid
out_ready  input  1  downstream accepts pair
out_level  output  BIT_LENGTH+1  signed nonzero coefficient
out_run  output  RUN_W  zeros preceding this coefficient in scan order (since previous nonzero or scan start)
out_last  output  1  pair is the final nonzero of the block
block_done  output  1  one-cycle pulse, block finished
total_coeff  output  5  nonzero count of finished block (0..16)
trailing_ones  output  2  consecutive ±1 at end of nonzero sequence, saturated at 3

Behaviour:
- Reset (reset low, asynchronous): state IDLE; in_ready=0 while reset asserted, 1 on the first cycle after release when enable=1. out_valid=0, out_level=0, out_run=0, out_last=0, block_done=0, total_coeff=0, trailing_ones=0. Internal buffer, mask and counters cleared.
- Zigzag order, raster indices by scan position: 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
- in_ready = (state==IDLE) & enable.
- IDLE: on in_valid&in_ready, perform the load in one cycle: latch all 16 coefficients and ac_only, build a 16-bit nonzero mask in scan order, and clear run, count and ones counters. Set k=1 if ac_only, else k=0. Go to SCAN.
- SCAN, one scan position per cycle while enable=1:
  - Zero coefficient: run++ and k++.
  - Nonzero coefficient: drive the pair registered: out_valid=1, out_level=coeff, out_run=run, out_last=(mask bits above k all zero). Go to EMIT.
  - After position 15 with no pending pair: go to DONE.
- EMIT: hold all output fields stable while out_valid&!out_ready. On handshake:
  - run=0 and count++.
  - ones = (|level|==1) ? min(ones+1,3) : 0.
  - If out_last, go to DONE; else k++ and return to SCAN.
  - out_valid drops the cycle after handshake unless a new pair is produced. No back-to-back pair on consecutive cycles is required; throughput is one pair per 2 cycles minimum.
- DONE: block_done=1 for exactly one cycle. total_coeff and trailing_ones update that same cycle and hold until the next DONE. Go to IDLE.
- All-zero block: no pairs. block_done occurs 16 SCAN cycles after load (15 if ac_only), with total_coeff=0 and trailing_ones=0.
- enable low: state, k, buffer and outputs freeze. out_valid stays asserted if already asserted, but a handshake occurring while enable=0 is ignored. block_done, if due, is delayed until enable returns.
- A new block is never accepted before block_done of the current one.
- Latency: load to first pair = 1 + (scan positions before the first nonzero) cycles.
- Level value is passed through unmodified: full width, no clipping, sign preserved. |level|==1 check covers both +1 and -1 (all-ones pattern).

Optional Feature:
FIELD_SCAN_EN:
- Defined: adds input field_mode (1 bit, sampled at load). When field_mode=1, the field scan order is used: 0,4,1,8,12,5,9,13,2,6,10,14,3,7,11,15.
- Undefined: port absent, frame zigzag only, and the scan table is a constant.

Test Plan:
- Block with raster coeff[0]=5, coeff[1]=-1, coeff[5]=1, rest 0 -> pairs (5,run0),(-1,run0),(1,run2,last); total_coeff=3, trailing_ones=2.
- All-zero block, ac_only=0 -> no out_valid; block_done exactly 17 cycles after the load edge; total_coeff=0.
- ac_only=1 with coeff[0]=9, coeff[15]=-1 -> single pair (-1, run14, last); DC ignored; total_coeff=1, trailing_ones=1.
- All 16 coefficients =1 with out_ready toggling randomly -> 16 pairs, each run=0, fields stable while stalled; total_coeff=16, trailing_ones=3.
- Reset asserted mid-EMIT with out_valid=1 -> all outputs 0 immediately (asynchronous); after release, in_ready=1 and the next block is processed correctly.
- enable dropped for 5 cycles during SCAN of a {coeff[8]=-300} block -> pair (-300, run3, last) delayed by exactly 5 cycles; in_ready stays 0 throughout.
